// File: rtl/pipe_regfile_if.sv
// Decode/writeback bus of the pipeline register file: read ports, writeback, issue and
// scoreboard status. The master drives the pipeline side and the slave is the register file.
interface pipe_regfile_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2
);
    localparam int ADDR_W = $clog2(NREGS);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic                     wr_link;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_valid;
    logic                     iss_link;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;
    logic                     wr_unexp;

    modport master (
        output rd_addr, wr_en, wr_link, wr_addr, wr_data,
               iss_valid, iss_link, iss_addr, flush,
        input  rd_data, rd_busy, busy_cnt, wr_unexp
    );

    modport slave (
        input  rd_addr, wr_en, wr_link, wr_addr, wr_data,
               iss_valid, iss_link, iss_addr, flush,
        output rd_data, rd_busy, busy_cnt, wr_unexp
    );
endinterface

// File: rtl/pipe_regfile.sv
// Pipeline register file with JAL link-register override, pending-write scoreboard and
// unexpected-writeback flag. Define REGFILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module pipe_regfile #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = 31
) (
    input  logic          clk,
    input  logic          rst,
    pipe_regfile_if.slave bus
);
    localparam int ADDR_W = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              wr_unexp_q, wr_unexp_d;
    logic              flush_q;

    logic [ADDR_W-1:0] wa, ia;
    logic              wr_hit, iss_hit;

    assign wa      = bus.wr_link  ? LINK_A : bus.wr_addr;
    assign ia      = bus.iss_link ? LINK_A : bus.iss_addr;
    assign wr_hit  = bus.wr_en     && (wa != '0);
    assign iss_hit = bus.iss_valid && (ia != '0);

    // Issue is applied after writeback so a newer producer keeps the register pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (wr_hit)  busy_d[wa] = 1'b0;
            if (iss_hit) busy_d[ia] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    // Writebacks of flushed ops still arrive in the flush cycle and the one after.
    assign wr_unexp_d = wr_hit && !busy_q[wa] && !bus.flush && !flush_q;

    // NOTE: the array is reset explicitly because reads must return 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_hit) begin
            regs_q[wa] <= bus.wr_data;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            wr_unexp_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            wr_unexp_q <= wr_unexp_d;
            flush_q    <= bus.flush;
        end
    end

    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    // Register 0 is never written and never pending, so it reads as 0 without a special case.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_c[k*DATA_W +: DATA_W] = regs_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
            rd_busy_c[k]                  = busy_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (bus.rd_addr[k*ADDR_W +: ADDR_W] == wa)) begin
                rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
                rd_busy_c[k]                  = iss_hit && (ia == wa);
            end
`else
`endif
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_cnt = busy_cnt_q;
    assign bus.wr_unexp = wr_unexp_q;
endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: reset, write latency, link override, r0, scoreboard,
// flush suppression and the unexpected-writeback pulse. Expectations follow REGFILE_BYPASS_EN.
module tb_pipe_regfile;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int ADDR_W = $clog2(NREGS);

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipe_regfile_if #(.DATA_W(DATA_W), .NREGS(NREGS), .NUM_RD(NUM_RD)) bus ();

    pipe_regfile #(
        .DATA_W(DATA_W), .NREGS(NREGS), .NUM_RD(NUM_RD), .LINK_REG(31)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.wr_en     = 1'b0;
        bus.wr_link   = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.iss_valid = 1'b0;
        bus.iss_link  = 1'b0;
        bus.iss_addr  = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_rd(input int port, input logic [ADDR_W-1:0] a);
        bus.rd_addr[port*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic do_iss(input logic [ADDR_W-1:0] a);
        bus.iss_valid = 1'b1;
        bus.iss_addr  = a;
    endtask

    function automatic logic [DATA_W-1:0] rdd(input int k);
        return bus.rd_data[k*DATA_W +: DATA_W];
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.rd_addr = '0;
        #1;
        check("reset_rd_data", 64'(rdd(0)), 64'h0);
        check("reset_busy_cnt", 64'(bus.busy_cnt), 64'h0);
        check("reset_wr_unexp", 64'(bus.wr_unexp), 64'h0);
        #10 rst = 1'b0;
        tick();

        // Write r5 to a non-pending register: one-cycle wr_unexp pulse.
        do_wr(5, 32'hDEAD);
        set_rd(0, 5);
        set_rd(1, 0);
        settle();
`ifdef REGFILE_BYPASS_EN
        check("r5_wr_cycle", 64'(rdd(0)), 64'hDEAD);
`else
        check("r5_wr_cycle", 64'(rdd(0)), 64'h0);
`endif
        tick();
        idle();
        do_iss(3);
        settle();
        check("r5_after", 64'(rdd(0)), 64'hDEAD);
        check("r5_unexp_pulse", 64'(bus.wr_unexp), 64'h1);
        tick();
        idle();
        settle();
        check("r5_unexp_drop", 64'(bus.wr_unexp), 64'h0);
        check("iss_r3_cnt", 64'(bus.busy_cnt), 64'h1);

        // Mid-cycle asynchronous reset.
        #2 rst = 1'b1;
        #1;
        check("midrst_rd_data", 64'(rdd(0)), 64'h0);
        check("midrst_busy_cnt", 64'(bus.busy_cnt), 64'h0);
        #1 rst = 1'b0;
        tick();

        // Issue r7, writeback three cycles later.
        do_iss(7);
        set_rd(0, 7);
        settle();
        check("r7_busy_pre", 64'(bus.rd_busy[0]), 64'h0);
        tick();
        idle();
        settle();
        check("r7_busy_c1", 64'(bus.rd_busy[0]), 64'h1);
        check("r7_cnt_c1", 64'(bus.busy_cnt), 64'h1);
        tick();
        check("r7_busy_c2", 64'(bus.rd_busy[0]), 64'h1);
        tick();
        do_wr(7, 32'h1234);
        settle();
`ifdef REGFILE_BYPASS_EN
        check("r7_wr_data", 64'(rdd(0)), 64'h1234);
        check("r7_wr_busy", 64'(bus.rd_busy[0]), 64'h0);
`else
        check("r7_wr_data", 64'(rdd(0)), 64'h0);
        check("r7_wr_busy", 64'(bus.rd_busy[0]), 64'h1);
`endif
        tick();
        idle();
        settle();
        check("r7_data", 64'(rdd(0)), 64'h1234);
        check("r7_busy_clr", 64'(bus.rd_busy[0]), 64'h0);
        check("r7_cnt_clr", 64'(bus.busy_cnt), 64'h0);
        check("r7_expected_wb", 64'(bus.wr_unexp), 64'h0);

        // Link override and register 0.
        do_wr(4, 32'h0040_0100);
        bus.wr_link = 1'b1;
        tick();
        idle();
        set_rd(0, 31);
        set_rd(1, 4);
        settle();
        check("link_r31", 64'(rdd(0)), 64'h0040_0100);
        check("link_r4_untouched", 64'(rdd(1)), 64'h0);
        check("link_unexp", 64'(bus.wr_unexp), 64'h1);
        do_wr(0, 32'hFFFF_FFFF);
        do_iss(0);
        tick();
        idle();
        set_rd(0, 0);
        settle();
        check("r0_reads_zero", 64'(rdd(0)), 64'h0);
        check("r0_no_unexp", 64'(bus.wr_unexp), 64'h0);
        check("r0_no_busy", 64'(bus.busy_cnt), 64'h0);

        // Same-cycle issue and writeback to r9: data lands, issue keeps it pending.
        do_iss(9);
        do_wr(9, 32'h99);
        set_rd(0, 9);
        settle();
`ifdef REGFILE_BYPASS_EN
        check("r9_bypass_data", 64'(rdd(0)), 64'h99);
        check("r9_bypass_busy", 64'(bus.rd_busy[0]), 64'h1);
`endif
        tick();
        idle();
        settle();
        check("r9_data", 64'(rdd(0)), 64'h99);
        check("r9_busy", 64'(bus.rd_busy[0]), 64'h1);
        check("r9_cnt", 64'(bus.busy_cnt), 64'h1);
        check("r9_unexp", 64'(bus.wr_unexp), 64'h1);

        // Issue r10 and writeback r11 together; r9 is still pending.
        do_iss(10);
        do_wr(11, 32'hB0B);
        tick();
        idle();
        set_rd(0, 10);
        set_rd(1, 11);
        settle();
        check("r10_busy", 64'(bus.rd_busy[0]), 64'h1);
        check("r11_data", 64'(rdd(1)), 64'hB0B);
        check("r10_cnt", 64'(bus.busy_cnt), 64'h2);

        // Issue r1..r3, then flush with a same-cycle issue of r4 and writeback of r1.
        do_iss(1);
        tick();
        do_iss(2);
        tick();
        do_iss(3);
        tick();
        idle();
        settle();
        check("pre_flush_cnt", 64'(bus.busy_cnt), 64'h5);
        bus.flush = 1'b1;
        do_iss(4);
        do_wr(1, 32'h11);
        tick();
        idle();
        do_wr(2, 32'h22);
        set_rd(0, 4);
        settle();
        check("flush_cnt", 64'(bus.busy_cnt), 64'h0);
        check("flush_r4_busy", 64'(bus.rd_busy[0]), 64'h0);
        check("flush_cycle_unexp", 64'(bus.wr_unexp), 64'h0);
        tick();
        idle();
        do_wr(3, 32'h33);
        set_rd(1, 2);
        settle();
        check("post_flush_unexp", 64'(bus.wr_unexp), 64'h0);
        check("post_flush_r2", 64'(rdd(1)), 64'h22);
        tick();
        idle();
        settle();
        check("late_unexp", 64'(bus.wr_unexp), 64'h1);

        // Standalone unexpected writeback to r6.
        tick();
        do_wr(6, 32'h66);
        tick();
        idle();
        settle();
        check("r6_unexp_on", 64'(bus.wr_unexp), 64'h1);
        tick();
        check("r6_unexp_off", 64'(bus.wr_unexp), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
